// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART Wishbone host and its slave wrapper.
// Register map, STATUS bit positions and host FSM states.
package uart_wb_pkg;

  localparam logic [3:0] REG_TX_DATA = 4'h0;
  localparam logic [3:0] REG_RX_DATA = 4'h1;
  localparam logic [3:0] REG_STATUS  = 4'h2;

  localparam int STATUS_TX_BUSY  = 0;
  localparam int STATUS_RX_VALID = 1;
  localparam int STATUS_RX_BREAK = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT,
    S_DEC,
    S_RXRD,
    S_TXWR
  } state_t;

endpackage

// File: rtl/uart_wb_host_port.sv
// Single-transfer Wishbone initiator port with ack timeout.
// Bus fields are registered by the sequencer; this adds done/err.
module wb_master_port #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic       we,
  input  logic [3:0] adr,
  input  logic [7:0] dat,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [3:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  assign wb_cyc_o = req;
  assign wb_stb_o = req;
  assign wb_we_o  = we;
  assign wb_adr_o = adr;
  assign wb_dat_o = dat;
  assign rdata    = wb_dat_i;

  // ack outside a cycle is ignored; ack on the last cycle still wins
  assign done = req && wb_ack_i;
  assign err  = req && !wb_ack_i
             && (tcnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
    end else if (!req) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// Polls the UART register slave over Wishbone and bridges it
// to simple valid/ready byte streams.
module uart_wb_host
  import uart_wb_pkg::*;
#(
  parameter int POLL_DIV    = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [3:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_break_o,
  output logic       bus_err_o
);

  localparam int PW = $clog2(POLL_DIV + 1);

  state_t        state;
  logic          req;
  logic          we;
  logic [3:0]    adr;
  logic [7:0]    dat;
  logic [1:0]    stat;
  logic [7:0]    hold;
  logic [PW-1:0] pcnt;
  logic          done;
  logic          err;
  logic [7:0]    rdata;

  wb_master_port #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_port (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .we       (we),
    .adr      (adr),
    .dat      (dat),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      req        <= 1'b0;
      we         <= 1'b0;
      adr        <= '0;
      dat        <= '0;
      stat       <= '0;
      hold       <= '0;
      pcnt       <= '0;
      tx_ready_o <= 1'b1;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_break_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      rx_break_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (tx_valid_i && tx_ready_o) begin
        hold       <= tx_data_i;
        tx_ready_o <= 1'b0;
      end
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      // abort leaves the tx byte pending for a later retry
      if (err) begin
        req       <= 1'b0;
        bus_err_o <= 1'b1;
        pcnt      <= '0;
        state     <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (pcnt == PW'(POLL_DIV - 1)) begin
              pcnt  <= '0;
              req   <= 1'b1;
              we    <= 1'b0;
              adr   <= REG_STATUS;
              state <= S_STAT;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          S_STAT: begin
            if (done) begin
              req        <= 1'b0;
              stat       <= rdata[1:0];
              rx_break_o <= rdata[STATUS_RX_BREAK];
              state      <= S_DEC;
            end
          end
          S_DEC: begin
            if (stat[STATUS_RX_VALID] && !rx_valid_o) begin
              req   <= 1'b1;
              we    <= 1'b0;
              adr   <= REG_RX_DATA;
              state <= S_RXRD;
            end else if (!tx_ready_o && !stat[STATUS_TX_BUSY]) begin
              req   <= 1'b1;
              we    <= 1'b1;
              adr   <= REG_TX_DATA;
              dat   <= hold;
              state <= S_TXWR;
            end else begin
              pcnt  <= '0;
              state <= S_IDLE;
            end
          end
          S_RXRD: begin
            if (done) begin
              req                   <= 1'b0;
              rx_valid_o            <= 1'b1;
              rx_data_o             <= rdata;
              stat[STATUS_RX_VALID] <= 1'b0;
              state                 <= S_DEC;
            end
          end
          S_TXWR: begin
            if (done) begin
              req        <= 1'b0;
              we         <= 1'b0;
              tx_ready_o <= 1'b1;
              pcnt       <= '0;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
